terminal_arbiter: RTL

- Sequential arbiter that shares the two output terminals (LED bank and LED matrix) between the two user stations (IS01, IS02).
- Each station presents its encoded 3-bit function code (post permission-AND and encoder) and a target terminal select.
- The block grants each terminal to one station at a time, holds the code on that terminal for a fixed display time, then blanks for a guard gap.
- Sits between the per-station encoder/selector logic and the matrix/LED decoders, replacing the combinational terminal selector muxing.

---
 rtl/pbl_term_pkg.sv | 29 ++
 rtl/terminal_slot.sv | 128 ++++++++++++
 rtl/terminal_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pbl_term_pkg.sv
// Shared definitions for the terminal arbiter slice.
// Holds the terminal-select encodings, the "no function" code, the
// per-terminal FSM state type and the candidate-qualification helper used
// by the top level to steer requests into the matrix and LED slots.
package pbl_term_pkg;

  // Target select encoding presented by each station.
  localparam logic TGT_MATRIZ = 1'b0;
  localparam logic TGT_LEDS   = 1'b1;

  // Function code meaning "denied / no function"; never shown on a terminal.
  localparam logic [2:0] CODE_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } term_state_t;

  // A station competes for a terminal only when it is eligible (req & armed),
  // carries a real function code and points its target at that terminal.
  function automatic logic is_candidate(input logic       eligible,
                                        input logic [2:0] code,
                                        input logic       tgt,
                                        input logic       slot_tgt);
    return eligible && (code != CODE_NONE) && (tgt == slot_tgt);
  endfunction

endpackage

// File: rtl/terminal_slot.sv
// One output terminal (matrix or LED bank): arbitration between the two
// stations, display hold timer, guard gap timer and the terminal's output
// registers.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | terminal free; grants a candidate on the next edge
// SHOW  | code displayed; counts down the hold time or ends on owner release
// GAP   | blanked guard interval before the terminal may be granted again
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   cand0, cand1      station is a qualified candidate for this terminal
//   code0, code1      station function codes (latched at the grant edge)
//   rel0, rel1        early release requests; only the owner's is honoured
//   take0, take1      combinational grant decision for this edge (top
//                     registers these into the ack pulses and disarms)
//   valid             terminal is showing a granted code
//   code              displayed code, CODE_NONE whenever not valid
//   owner             station that owns / last owned the terminal
module terminal_slot
  import pbl_term_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cand0,
  input  logic       cand1,
  input  logic [2:0] code0,
  input  logic [2:0] code1,
  input  logic       rel0,
  input  logic       rel1,
  output logic       take0,
  output logic       take1,
  output logic       valid,
  output logic [2:0] code,
  output logic       owner
);

  // Counter is loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  term_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             rr_ptr;    // station that wins the next tie
  logic             rel_owner;

  // Grant decision: a lone candidate always wins; a tie goes to rr_ptr.
  always_comb begin
    take0 = 1'b0;
    take1 = 1'b0;
    if (state == IDLE) begin
      if (cand0 && cand1) begin
        take0 = ~rr_ptr;
        take1 = rr_ptr;
      end else begin
        take0 = cand0;
        take1 = cand1;
      end
    end
  end

  assign rel_owner = owner ? rel1 : rel0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rr_ptr <= 1'b0;
      valid  <= 1'b0;
      code   <= CODE_NONE;
      owner  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take0 || take1) begin
            state <= SHOW;
            valid <= 1'b1;
            code  <= take1 ? code1 : code0;
            owner <= take1;
            cnt   <= HOLD_LOAD;
            // Pointer only moves when it actually settled a tie.
            if (cand0 && cand1) begin
              rr_ptr <= ~rr_ptr;
            end
          end
        end

        SHOW: begin
          if ((cnt == '0) || rel_owner) begin
            valid <= 1'b0;
            code  <= CODE_NONE;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          valid <= 1'b0;
          code  <= CODE_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/terminal_arbiter.sv
// Shares the matrix and LED-bank terminals between stations IS01/IS02.
// Each station issues a level request with a target select and a 3-bit
// function code; the block acknowledges each request exactly once, rejects
// code 000 without touching a terminal, and otherwise hands the request to
// the terminal slot it targets.
//
// Ports:
//   clk, rst_n                  system clock, async active-low reset
//   req0/tgt0/code0/rel0        station 0 request, target (0 matrix, 1 LEDs),
//                               function code, early release
//   req1/tgt1/code1/rel1        same for station 1
//   ack0, ack1                  one-cycle accept pulse
//   rej0, rej1                  one-cycle reject pulse (with ack) for code 000
//   mat_valid/mat_code/mat_owner  matrix terminal outputs
//   led_valid/led_code/led_owner  LED bank terminal outputs
module terminal_arbiter
  import pbl_term_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 1,
  // 2**CNT_W must exceed max(HOLD_CYCLES, GAP_CYCLES).
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       tgt0,
  input  logic [2:0] code0,
  input  logic       rel0,
  input  logic       req1,
  input  logic       tgt1,
  input  logic [2:0] code1,
  input  logic       rel1,
  output logic       ack0,
  output logic       ack1,
  output logic       rej0,
  output logic       rej1,
  output logic       mat_valid,
  output logic [2:0] mat_code,
  output logic       mat_owner,
  output logic       led_valid,
  output logic [2:0] led_code,
  output logic       led_owner
);

  logic armed0, armed1;
  logic elig0, elig1;
  logic rej_take0, rej_take1;
  logic cand_m0, cand_m1, cand_l0, cand_l1;
  logic take_m0, take_m1, take_l0, take_l1;
  logic take0, take1;

  assign elig0 = req0 & armed0;
  assign elig1 = req1 & armed1;

  // Code 000 is answered immediately, whatever the terminals are doing.
  assign rej_take0 = elig0 & (code0 == CODE_NONE);
  assign rej_take1 = elig1 & (code1 == CODE_NONE);

  assign cand_m0 = is_candidate(elig0, code0, tgt0, TGT_MATRIZ);
  assign cand_m1 = is_candidate(elig1, code1, tgt1, TGT_MATRIZ);
  assign cand_l0 = is_candidate(elig0, code0, tgt0, TGT_LEDS);
  assign cand_l1 = is_candidate(elig1, code1, tgt1, TGT_LEDS);

  terminal_slot #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_mat (
    .clk   (clk),
    .rst_n (rst_n),
    .cand0 (cand_m0),
    .cand1 (cand_m1),
    .code0 (code0),
    .code1 (code1),
    .rel0  (rel0),
    .rel1  (rel1),
    .take0 (take_m0),
    .take1 (take_m1),
    .valid (mat_valid),
    .code  (mat_code),
    .owner (mat_owner)
  );

  terminal_slot #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_led (
    .clk   (clk),
    .rst_n (rst_n),
    .cand0 (cand_l0),
    .cand1 (cand_l1),
    .code0 (code0),
    .code1 (code1),
    .rel0  (rel0),
    .rel1  (rel1),
    .take0 (take_l0),
    .take1 (take_l1),
    .valid (led_valid),
    .code  (led_code),
    .owner (led_owner)
  );

  // A station targets exactly one terminal, so at most one source fires.
  assign take0 = take_m0 | take_l0 | rej_take0;
  assign take1 = take_m1 | take_l1 | rej_take1;

  // Disarming at the decision edge keeps a still-high req from being
  // granted again in the cycle where its ack is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed0 <= 1'b1;
      armed1 <= 1'b1;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rej0   <= 1'b0;
      rej1   <= 1'b0;
    end else begin
      ack0 <= take0;
      ack1 <= take1;
      rej0 <= rej_take0;
      rej1 <= rej_take1;

      if (take0)      armed0 <= 1'b0;
      else if (!req0) armed0 <= 1'b1;

      if (take1)      armed1 <= 1'b0;
      else if (!req1) armed1 <= 1'b1;
    end
  end

endmodule
